// File: rtl/keypad_code_lock_if.sv
// Keypad-side bundle for the code lock: digit/command strobes in, status and pulses out.
interface keypad_code_lock_if #(
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned CODE_LEN  = 4,
  parameter int unsigned MAX_TRIES = 3
);
  localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               clear_key;
  logic               set_mode;
  logic               lock_cmd;
  logic               unlocked;
  logic               lockout;
  logic               ok_pulse;
  logic               fail_pulse;
  logic [CNT_W-1:0]   entry_count;
  logic [TRY_W-1:0]   tries_left;

  // Keypad scanner / top-level side.
  modport master (
    output digit_valid, digit, clear_key, set_mode, lock_cmd,
    input  unlocked, lockout, ok_pulse, fail_pulse, entry_count, tries_left
  );

  // Lock controller side.
  modport slave (
    input  digit_valid, digit, clear_key, set_mode, lock_cmd,
    output unlocked, lockout, ok_pulse, fail_pulse, entry_count, tries_left
  );
endinterface

// File: rtl/keypad_code_lock.sv
// Code-entry controller: checks a CODE_LEN-digit entry against a stored code, counts failed
// attempts, enforces a timed lockout and allows re-programming the code while open.
module keypad_code_lock #(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 36_000_000,
  parameter int unsigned IDLE_CYCLES    = 60_000_000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input logic                hwclk,
  input logic                reset,
  keypad_code_lock_if.slave  bus
);

  localparam int unsigned CODE_W = CODE_LEN * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W  = 32;

  typedef enum logic [1:0] {
    S_LOCKED,
    S_OPEN,
    S_NEWCODE,
    S_LOCKOUT
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]    entry_q, entry_d;
  logic                mismatch_q, mismatch_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [TMR_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [TMR_W-1:0]    idle_q, idle_d;
  logic                ok_q, ok_d;
  logic                fail_q, fail_d;
  logic                unlocked_q, unlocked_d;
  logic                lockout_q, lockout_d;

  logic [DIGIT_W-1:0]  exp_digit_c;
  logic                digit_bad_c;
  logic                last_digit_c;
  logic                partial_c;
  logic                idle_expired_c;
  logic [CODE_W-1:0]   shadow_next_c;

  // Stored-code digit selected by the current entry position (digit 0 in the MS bits).
  always_comb begin
    exp_digit_c = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (32'(entry_q) == i) begin
        exp_digit_c = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign digit_bad_c    = (bus.digit != exp_digit_c);
  assign last_digit_c   = (32'(entry_q) == (CODE_LEN - 1));
  assign partial_c      = (entry_q != '0);
  assign idle_expired_c = (idle_q >= TMR_W'(IDLE_CYCLES - 1));
  assign shadow_next_c  = (shadow_q << DIGIT_W) | CODE_W'(bus.digit);

  // State register and all registered outputs; reset restores the default code.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q    <= S_LOCKED;
      code_q     <= DEFAULT_CODE;
      shadow_q   <= '0;
      entry_q    <= '0;
      mismatch_q <= 1'b0;
      tries_q    <= TRY_W'(MAX_TRIES);
      lock_cnt_q <= '0;
      idle_q     <= '0;
      ok_q       <= 1'b0;
      fail_q     <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      shadow_q   <= shadow_d;
      entry_q    <= entry_d;
      mismatch_q <= mismatch_d;
      tries_q    <= tries_d;
      lock_cnt_q <= lock_cnt_d;
      idle_q     <= idle_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
    end
  end

  // Next-state, counters and pulse generation; outputs decoded from the next state.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    entry_d    = entry_q;
    mismatch_d = mismatch_q;
    tries_d    = tries_q;
    lock_cnt_d = lock_cnt_q;
    idle_d     = '0;
    ok_d       = 1'b0;
    fail_d     = 1'b0;

    unique case (state_q)
      S_LOCKED: begin
        if (bus.clear_key) begin
          entry_d    = '0;
          mismatch_d = 1'b0;
        end else if (bus.digit_valid) begin
          if (last_digit_c) begin
            entry_d    = '0;
            mismatch_d = 1'b0;
            if (mismatch_q || digit_bad_c) begin
              fail_d  = 1'b1;
              tries_d = (tries_q == '0) ? '0 : tries_q - TRY_W'(1);
              if (tries_q <= TRY_W'(1)) begin
                state_d    = S_LOCKOUT;
                lock_cnt_d = '0;
              end
            end else begin
              ok_d    = 1'b1;
              tries_d = TRY_W'(MAX_TRIES);
              state_d = S_OPEN;
            end
          end else begin
            entry_d    = entry_q + CNT_W'(1);
            mismatch_d = mismatch_q | digit_bad_c;
          end
        end else if (partial_c) begin
          // Abandoned partial entry is dropped without costing a try.
          if (idle_expired_c) begin
            entry_d    = '0;
            mismatch_d = 1'b0;
          end else begin
            idle_d = idle_q + TMR_W'(1);
          end
        end
      end

      S_OPEN: begin
        if (bus.lock_cmd) begin
          state_d = S_LOCKED;
        end else if (bus.set_mode) begin
          state_d    = S_NEWCODE;
          entry_d    = '0;
          mismatch_d = 1'b0;
        end
      end

      S_NEWCODE: begin
        if (bus.lock_cmd) begin
          state_d    = S_LOCKED;
          shadow_d   = '0;
          entry_d    = '0;
          mismatch_d = 1'b0;
        end else if (bus.clear_key) begin
          entry_d = '0;
        end else if (bus.digit_valid) begin
          shadow_d = shadow_next_c;
          if (last_digit_c) begin
            code_d  = shadow_next_c;
            entry_d = '0;
            ok_d    = 1'b1;
            state_d = S_OPEN;
          end else begin
            entry_d = entry_q + CNT_W'(1);
          end
        end else if (partial_c) begin
          if (idle_expired_c) begin
            entry_d = '0;
          end else begin
            idle_d = idle_q + TMR_W'(1);
          end
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt_q >= TMR_W'(LOCKOUT_CYCLES - 1)) begin
          state_d    = S_LOCKED;
          tries_d    = TRY_W'(MAX_TRIES);
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + TMR_W'(1);
        end
      end

      default: state_d = S_LOCKED;
    endcase

    unlocked_d = (state_d == S_OPEN) || (state_d == S_NEWCODE);
    lockout_d  = (state_d == S_LOCKOUT);
  end

  assign bus.unlocked    = unlocked_q;
  assign bus.lockout     = lockout_q;
  assign bus.ok_pulse    = ok_q;
  assign bus.fail_pulse  = fail_q;
  assign bus.entry_count = entry_q;
  assign bus.tries_left  = tries_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed bench for keypad_code_lock: vector table plus hand-written multi-cycle sequences.
module tb_keypad_code_lock;

  localparam int unsigned LOCKOUT = 20;
  localparam int unsigned IDLE    = 10;

  logic hwclk = 1'b0;
  logic reset = 1'b1;

  always #5 hwclk = ~hwclk;

  keypad_code_lock_if #(.DIGIT_W(4), .CODE_LEN(4), .MAX_TRIES(3)) bus ();

  keypad_code_lock #(
    .CODE_LEN(4), .DIGIT_W(4), .MAX_TRIES(3),
    .LOCKOUT_CYCLES(LOCKOUT), .IDLE_CYCLES(IDLE),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .hwclk(hwclk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       clr;
    logic       sm;
    logic       lk;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  // Expected status packed as {unlocked, lockout, ok, fail, entry_count[2:0], tries_left[1:0]}.
  function automatic logic [8:0] pk(input logic ul, input logic lo, input logic ok,
                                    input logic fl, input int ec, input int tl);
    return {ul, lo, ok, fl, 3'(ec), 2'(tl)};
  endfunction

  function automatic logic [8:0] status();
    return {bus.unlocked, bus.lockout, bus.ok_pulse, bus.fail_pulse, bus.entry_count, bus.tries_left};
  endfunction

  task automatic add(input logic dv, input logic [3:0] d, input logic clr, input logic sm,
                     input logic lk, input logic [8:0] exp);
    vec_t v;
    v.dv = dv; v.d = d; v.clr = clr; v.sm = sm; v.lk = lk; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.digit_valid = 1'b0; bus.digit = '0; bus.clear_key = 1'b0;
    bus.set_mode = 1'b0; bus.lock_cmd = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit = d;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic fail_seen;
    string nm;

    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    check("reset_state", 32'(status()), 32'(pk(0, 0, 0, 0, 0, 3)));

    // Correct default code opens after 4th digit; OPEN ignores digits; lock beats set_mode.
    add(1, 1, 0, 0, 0, pk(0, 0, 0, 0, 1, 3));
    add(1, 2, 0, 0, 0, pk(0, 0, 0, 0, 2, 3));
    add(1, 3, 0, 0, 0, pk(0, 0, 0, 0, 3, 3));
    add(1, 4, 0, 0, 0, pk(1, 0, 1, 0, 0, 3));
    add(0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 3));
    add(1, 5, 0, 0, 0, pk(1, 0, 0, 0, 0, 3));
    add(0, 0, 0, 1, 1, pk(0, 0, 0, 0, 0, 3));
    add(0, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 3));
    // clear_key wins over a simultaneous digit and costs no try.
    add(1, 1, 0, 0, 0, pk(0, 0, 0, 0, 1, 3));
    add(1, 2, 0, 0, 0, pk(0, 0, 0, 0, 2, 3));
    add(1, 3, 1, 0, 0, pk(0, 0, 0, 0, 0, 3));
    add(1, 1, 0, 0, 0, pk(0, 0, 0, 0, 1, 3));
    add(1, 2, 0, 0, 0, pk(0, 0, 0, 0, 2, 3));
    add(1, 3, 0, 0, 0, pk(0, 0, 0, 0, 3, 3));
    add(1, 4, 0, 0, 0, pk(1, 0, 1, 0, 0, 3));
    // Re-program to 9876, relock, old code fails, new code opens.
    add(0, 0, 0, 1, 0, pk(1, 0, 0, 0, 0, 3));
    add(1, 9, 0, 0, 0, pk(1, 0, 0, 0, 1, 3));
    add(1, 8, 0, 0, 0, pk(1, 0, 0, 0, 2, 3));
    add(1, 7, 0, 0, 0, pk(1, 0, 0, 0, 3, 3));
    add(1, 6, 0, 0, 0, pk(1, 0, 1, 0, 0, 3));
    add(0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 3));
    add(0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 3));
    add(1, 1, 0, 0, 0, pk(0, 0, 0, 0, 1, 3));
    add(1, 2, 0, 0, 0, pk(0, 0, 0, 0, 2, 3));
    add(1, 3, 0, 0, 0, pk(0, 0, 0, 0, 3, 3));
    add(1, 4, 0, 0, 0, pk(0, 0, 0, 1, 0, 2));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 2));
    add(1, 9, 0, 0, 0, pk(0, 0, 0, 0, 1, 2));
    add(1, 8, 0, 0, 0, pk(0, 0, 0, 0, 2, 2));
    add(1, 7, 0, 0, 0, pk(0, 0, 0, 0, 3, 2));
    add(1, 6, 0, 0, 0, pk(1, 0, 1, 0, 0, 3));
    // Aborted re-programming leaves the code unchanged.
    add(0, 0, 0, 1, 0, pk(1, 0, 0, 0, 0, 3));
    add(1, 1, 0, 0, 0, pk(1, 0, 0, 0, 1, 3));
    add(1, 1, 0, 0, 0, pk(1, 0, 0, 0, 2, 3));
    add(0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 3));
    add(1, 9, 0, 0, 0, pk(0, 0, 0, 0, 1, 3));
    add(1, 8, 0, 0, 0, pk(0, 0, 0, 0, 2, 3));
    add(1, 7, 0, 0, 0, pk(0, 0, 0, 0, 3, 3));
    add(1, 6, 0, 0, 0, pk(1, 0, 1, 0, 0, 3));
    add(0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 3));

    foreach (vecs[i]) begin
      bus.digit_valid = vecs[i].dv;
      bus.digit       = vecs[i].d;
      bus.clear_key   = vecs[i].clr;
      bus.set_mode    = vecs[i].sm;
      bus.lock_cmd    = vecs[i].lk;
      tick();
      nm = $sformatf("vec%0d", i);
      check(nm, 32'(status()), 32'(vecs[i].exp));
    end
    idle_inputs();

    // Three wrong entries (code is 9876) -> lockout for exactly LOCKOUT cycles.
    for (int a = 0; a < 3; a++) begin
      press(4'd1); press(4'd2); press(4'd3); press(4'd5);
      nm = $sformatf("wrong%0d", a);
      check(nm, 32'(status()), 32'(pk(0, (a == 2), 0, 1, 0, 2 - a)));
    end
    n = 0;
    fail_seen = 1'b0;
    while (bus.lockout && n < 100) begin
      n++;
      press(4'd9);
      fail_seen |= bus.fail_pulse | bus.ok_pulse | (bus.entry_count != '0);
    end
    check("lockout_len", 32'(n), 32'(LOCKOUT));
    check("lockout_ignored", 32'(fail_seen), 32'(0));
    check("after_lockout", 32'(status()), 32'(pk(0, 0, 0, 0, 0, 3)));

    // Idle timeout discards a partial entry without a fail pulse.
    press(4'd1); press(4'd2);
    check("idle_partial", 32'(bus.entry_count), 32'(2));
    fail_seen = 1'b0;
    for (int c = 0; c < int'(IDLE) - 1; c++) begin
      tick();
      fail_seen |= bus.fail_pulse;
    end
    check("idle_before", 32'(bus.entry_count), 32'(2));
    tick();
    fail_seen |= bus.fail_pulse;
    check("idle_cleared", 32'(status()), 32'(pk(0, 0, 0, 0, 0, 3)));
    check("idle_no_fail", 32'(fail_seen), 32'(0));

    // Reset mid re-programming restores the default code.
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    check("open_9876", 32'(status()), 32'(pk(1, 0, 1, 0, 0, 3)));
    bus.set_mode = 1'b1; tick(); bus.set_mode = 1'b0;
    press(4'd5); press(4'd5);
    check("newcode_partial", 32'(status()), 32'(pk(1, 0, 0, 0, 2, 3)));
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_mid", 32'(status()), 32'(pk(0, 0, 0, 0, 0, 3)));
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("default_after_reset", 32'(status()), 32'(pk(1, 0, 1, 0, 0, 3)));
    tick();
    check("ok_one_cycle", 32'(status()), 32'(pk(1, 0, 0, 0, 0, 3)));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
